// File: rtl/obstacle_word_streamer.sv
// Purpose: fetch one TOTAL_BITS obstacle-mask frame from BRAM and stream it as WORD_W-bit valid/ready words.
// Latency: first m_valid RD_LAT+2 cycles after start is sampled; one word per cycle when unstalled.
// Backpressure: reads are issued only when in-flight + FIFO entries fit the FIFO; in_collision_state pauses issue.
// Option: define MASK_TAIL_ZERO_EN to force the unused upper bits of the final word to zero.
module obstacle_word_streamer #(
  parameter int TOTAL_BITS = 2500,
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_collision_state,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [WORD_W-1:0] bram_dout,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_count
);

  localparam int NUM_WORDS = (TOTAL_BITS + WORD_W - 1) / WORD_W;
  localparam int REM       = TOTAL_BITS - (NUM_WORDS - 1) * WORD_W;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W    = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  NUM_V     = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0]  LAST_V    = CNT_W'(NUM_WORDS - 1);
  localparam logic [FCNT_W:0]   DEPTH_V   = (FCNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE_V    = ADDR_W'(BASE_ADDR);
`ifdef MASK_TAIL_ZERO_EN
  localparam logic [WORD_W-1:0] TAIL_MASK = (REM >= WORD_W) ? {WORD_W{1'b1}}
                                          : ((WORD_W'(1) << REM) - WORD_W'(1));
`endif

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   issued, xfer;
  logic [RD_LAT-1:0]  lat_sr;
  logic [WORD_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]  fifo_count;
  logic [FCNT_W:0]    inflight;
  logic               issue, push, pop, clear;

  // Reads still in the BRAM pipeline count against FIFO space.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + {{FCNT_W{1'b0}}, lat_sr[i]};
  end

  // Issue/landing/transfer qualifiers and stream outputs.
  always_comb begin
    issue     = (state == FETCH) && (issued < NUM_V) && !in_collision_state
                && (({1'b0, fifo_count} + inflight) < DEPTH_V);
    bram_en   = issue;
    bram_addr = BASE_V + ADDR_W'(issued);
    push      = lat_sr[RD_LAT-1];
    m_valid   = (fifo_count != '0);
    pop       = m_valid && m_ready;
    m_last    = m_valid && (xfer == LAST_V);
    m_data    = '0;
    if (m_valid) begin
      m_data = fifo_mem[rd_ptr];
`ifdef MASK_TAIL_ZERO_EN
      if (m_last) m_data = fifo_mem[rd_ptr] & TAIL_MASK;
`endif
    end
  end

  // Next-state logic; clear fires on frame acceptance.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    unique case (state)
      IDLE:  if (start) begin state_nxt = FETCH; clear = 1'b1; end
      FETCH: if (issue && (issued == LAST_V)) state_nxt = DRAIN;
      DRAIN: if (pop && m_last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State, counters and the read-latency valid pipe; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      issued      <= '0;
      xfer        <= '0;
      lat_sr      <= '0;
      frame_count <= '0;
    end else begin
      state     <= state_nxt;
      lat_sr[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) lat_sr[i] <= lat_sr[i-1];
      if (clear) begin
        issued <= '0;
        xfer   <= '0;
      end else begin
        if (issue) issued <= issued + 1'b1;
        if (pop)   xfer   <= xfer + 1'b1;
      end
      if (state == DONE) frame_count <= frame_count + 8'd1;
    end
  end

  // Output FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  // FIFO storage captures BRAM data as its read valid emerges.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bram_dout;
  end

endmodule

// File: doc/obstacle_word_streamer.md
# obstacle_word_streamer

Reads one obstacle-mask frame (TOTAL_BITS bits, packed WORD_W bits per BRAM word) out of block RAM and streams it as a valid/ready word stream. It sits directly upstream of the mask packer that assembles 32-bit words into the 2500-bit obstacle image. Its job is to keep BRAM read latency and consumer backpressure away from that packer. Word fetches pause while the lattice is in its collision phase.

## Interface
- TOTAL_BITS, 2500: mask bits per frame
- WORD_W, 32: BRAM and stream word width
- ADDR_W, 10: BRAM address width
- BASE_ADDR, 0: BRAM address of word 0
- RD_LAT, 2: BRAM read latency in cycles, legal range 1..3
- FIFO_DEPTH, 4: output FIFO entries; must be at least 1, and at least RD_LAT+2 for full throughput
- Derived: NUM_WORDS = ceil(TOTAL_BITS/WORD_W), which is 79 at the defaults; REM = TOTAL_BITS - (NUM_WORDS-1)*WORD_W, which is 4 at the defaults

Ports:
- clk  in  1  clock, rising edge; one clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one frame; sampled only in IDLE
- in_collision_state  in  1  while high, no new BRAM reads are issued
- bram_en  out  1  BRAM read enable
- bram_addr  out  ADDR_W  BRAM read address
- bram_dout  in  WORD_W  BRAM read data, valid RD_LAT cycles after bram_en
- m_data  out  WORD_W  stream word; head of the FIFO
- m_valid  out  1  stream word valid
- m_ready  in  1  consumer ready
- m_last  out  1  current word is word NUM_WORDS-1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a frame completes
- frame_count  out  8  count of completed frames, wraps 255 to 0

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE → FETCH when start=1. On entry, the issue counter, transfer counter and FIFO are cleared.
- A read is issued in FETCH when all of these hold:
  - issued < NUM_WORDS
  - in_collision_state = 0
  - inflight + fifo_count < FIFO_DEPTH
- A read issue asserts bram_en=1 with bram_addr = BASE_ADDR + issued, then increments issued.
- inflight is tracked by an RD_LAT-deep valid shift register. Data is written into the FIFO in the cycle its valid bit emerges from that register.
- FETCH → DRAIN on the cycle that issues read NUM_WORDS-1.
- m_valid = FIFO non-empty. A transfer happens when m_valid=1 and m_ready=1; it pops the FIFO and increments the transfer counter.
  - A push and a pop in the same cycle are both legal. fifo_count is then unchanged.
- m_last = m_valid and (transfer counter = NUM_WORDS-1).
- DRAIN → DONE on the transfer that has m_last=1.
- DONE lasts one cycle: done=1, frame_count increments, then the block returns to IDLE.
- start is ignored outside IDLE. start=1 in DONE has no effect.
- in_collision_state only gates new issues. In-flight reads still land in the FIFO, and FIFO draining continues.
- Reset takes priority over everything, including mid-frame. In-flight read data is discarded and never enters the FIFO.
- Reset values: state IDLE, bram_en=0, bram_addr=BASE_ADDR, m_valid=0, m_last=0, m_data=0, busy=0, done=0, frame_count=0.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- First bram_en: cycle 1.
- First m_valid: cycle RD_LAT+2.
- With m_ready held at 1 and in_collision_state=0, one word transfers per cycle with no bubbles (requires FIFO_DEPTH ≥ RD_LAT+2).
- Last transfer: cycle RD_LAT+NUM_WORDS+1, which is cycle 82 at the defaults.
- done: the cycle after the last transfer, cycle 83 at the defaults.
- busy: low again from cycle 84 at the defaults.
- A new start can be accepted at the earliest in the first IDLE cycle after DONE.
- m_data, m_valid and m_last hold stable while m_valid=1 and m_ready=0.

## Configuration
- MASK_TAIL_ZERO_EN defined: on the m_last word, bits [WORD_W-1:REM] are forced to 0, so only the REM meaningful LSBs pass through.
- MASK_TAIL_ZERO_EN undefined: the last word passes through unmodified, exactly as stored in BRAM.
- No other behaviour differs.

## Test plan
- Defaults, BRAM word k = k, m_ready=1, start in cycle 0:
  - m_valid rises in cycle 4; data 0..78 arrive in order.
  - m_last is high only on data=78 (cycle 82).
  - done is high in cycle 83; frame_count=1.
- m_ready toggled randomly (50%):
  - All 79 words arrive exactly once, in order.
  - The held word stays stable while m_ready=0.
  - The FIFO never exceeds 4 entries.
- in_collision_state held high for cycles 10–29:
  - No bram_en in that window.
  - In-flight words still transfer.
  - The stream resumes with the next address; all 79 words are delivered.
- Last BRAM word = 0xFFFFFFFF:
  - Observed m_data = 0x0000000F with MASK_TAIL_ZERO_EN defined.
  - Observed m_data = 0xFFFFFFFF without it.
- rst asserted in cycle 40:
  - Next cycle shows busy=0, m_valid=0, frame_count unchanged at 0.
  - A fresh start restarts from address BASE_ADDR, word 0.
- start pulsed at 1 in cycle 20 (mid-frame) and in the DONE cycle: both ignored, and exactly one frame completes.
